coderom_loader: RTL and testbench

- Boot-time sequencer for the 4×8 KB code ROM banks.
- Accepts a byte stream from the external flash/serial front-end and writes it linearly into banks 0..3.
- Verifies a 16-bit additive checksum, then hands the ROM read port to the CPU and releases CPU hold.
- Sits between the CPU address decode and the code ROM; also owns bank write enables.

---
 rtl/coderom_loader.sv | 90 +++++++++
 tb/tb_coderom_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/coderom_loader.sv
// Boot-time code ROM loader: streams bytes linearly into the ROM banks, verifies a
// 16-bit additive checksum, then hands the ROM read port to the CPU and releases hold.
module coderom_loader #(
  parameter int BANKS = 4,
  parameter int ABITS = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      exp_sum,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ABITS-1:0] wr_a,
  output logic [7:0]       wr_d,
  output logic [BANKS-1:0] wr_we,
  input  logic [ABITS-1:0] cpu_a,
  input  logic [BANKS-1:0] cpu_ce,
  output logic [ABITS-1:0] rom_a,
  output logic [BANKS-1:0] rom_ce,
  output logic             cpu_hold,
  output logic             done,
  output logic             error,
  output logic [15:0]      checksum
);

  localparam int BBITS = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam logic [BBITS-1:0] LAST_BANK = BBITS'(BANKS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, RUN, FAIL} state_t;

  state_t           state;
  logic [BBITS-1:0] bank;
  logic [ABITS-1:0] addr;
  logic             accept;
  logic             last_byte;

  assign in_ready  = (state == LOAD);
  assign accept    = in_valid && in_ready;
  assign last_byte = (bank == LAST_BANK) && (addr == '1);

  // The CPU only sees the ROM once writes can no longer happen.
  assign rom_a  = (state == RUN) ? cpu_a  : wr_a;
  assign rom_ce = (state == RUN) ? cpu_ce : '1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bank     <= '0;
      addr     <= '0;
      checksum <= '0;
      wr_we    <= '0;
      wr_a     <= '0;
      wr_d     <= '0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      wr_we    <= '0;
      cpu_hold <= (state != RUN);
      done     <= (state == RUN);
      error    <= (state == FAIL);
      case (state)
        IDLE, RUN, FAIL: begin
          if (start) begin
            state    <= LOAD;
            bank     <= '0;
            addr     <= '0;
            checksum <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            // Write is issued one cycle after acceptance; addr wraps into the next bank.
            wr_we    <= BANKS'(1) << bank;
            wr_a     <= addr;
            wr_d     <= in_data;
            checksum <= checksum + 16'(in_data);
            addr     <= addr + 1'b1;
            if (addr == '1) bank <= bank + 1'b1;
            if (last_byte) state <= CHECK;
          end
        end
        CHECK: state <= (checksum == exp_sum) ? RUN : FAIL;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coderom_loader.sv
// Directed self-checking bench for coderom_loader at default parameters.
module tb_coderom_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] exp_sum;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] wr_a;
  logic [7:0]  wr_d;
  logic [3:0]  wr_we;
  logic [12:0] cpu_a;
  logic [3:0]  cpu_ce;
  logic [12:0] rom_a;
  logic [3:0]  rom_ce;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] checksum;

  int checks = 0;
  int failures = 0;

  coderom_loader #(.BANKS(4), .ABITS(13)) dut (
    .clk(clk), .reset(reset), .start(start), .exp_sum(exp_sum),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_a(wr_a), .wr_d(wr_d), .wr_we(wr_we),
    .cpu_a(cpu_a), .cpu_ce(cpu_ce), .rom_a(rom_a), .rom_ce(rom_ce),
    .cpu_hold(cpu_hold), .done(done), .error(error), .checksum(checksum)
  );

  always #5 clk = ~clk;

  // Streams nbytes of the addr^bank pattern; reports bad-cycle count and the write seen for cap_idx.
  task automatic run_stream(input int nbytes, input bit gaps, input int start_at, input int cap_idx,
                            output int bad, output bit timed_out,
                            output logic [3:0] cap_we, output logic [12:0] cap_a, output logic [7:0] cap_d);
    int sent = 0;
    int cyc = 0;
    bit prev_acc = 0;
    int prev_idx = 0;
    bit v;
    logic [15:0] lfsr = 16'hACE1;
    logic [12:0] a;
    logic [1:0] b;
    bad = 0;
    timed_out = 0;
    cap_we = 'x;
    cap_a = 'x;
    cap_d = 'x;
    while (sent < nbytes) begin
      if (cyc > 60000) begin
        timed_out = 1;
        break;
      end
      a = prev_idx[12:0];
      b = prev_idx[14:13];
      if (prev_acc) begin
        if (prev_idx == cap_idx) begin
          cap_we = wr_we;
          cap_a = wr_a;
          cap_d = wr_d;
        end
        if (wr_we !== (4'b0001 << b) || wr_a !== a || wr_d !== (a[7:0] ^ {6'd0, b})) bad++;
      end else if (wr_we !== 4'b0000) bad++;
      if (in_ready !== 1'b1) bad++;
      v = gaps ? (lfsr[1:0] != 2'b00) : 1'b1;
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      a = sent[12:0];
      b = sent[14:13];
      in_valid = v;
      in_data = a[7:0] ^ {6'd0, b};
      start = (sent == start_at);
      @(posedge clk); #1;
      cyc++;
      start = 0;
      prev_acc = v;
      prev_idx = sent;
      if (v) sent++;
    end
    in_valid = 0;
    a = prev_idx[12:0];
    b = prev_idx[14:13];
    if (prev_acc) begin
      if (prev_idx == cap_idx) begin
        cap_we = wr_we;
        cap_a = wr_a;
        cap_d = wr_d;
      end
      if (wr_we !== (4'b0001 << b) || wr_a !== a || wr_d !== (a[7:0] ^ {6'd0, b})) bad++;
    end
  endtask

  task automatic test_reset();
    reset = 1; start = 0; exp_sum = 0; in_data = 0; in_valid = 0;
    cpu_a = 13'h0AAA; cpu_ce = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (wr_we !== 4'b0000 || wr_a !== 13'd0 || wr_d !== 8'd0) begin failures++;
      $display("[TB] FAIL reset_write: we=%b a=%h d=%h required 0/0/0", wr_we, wr_a, wr_d); end
    checks++; if (in_ready !== 1'b0 || checksum !== 16'd0) begin failures++;
      $display("[TB] FAIL reset_ready_sum: ready=%b sum=%h required 0/0000", in_ready, checksum); end
    checks++; if (cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin failures++;
      $display("[TB] FAIL reset_status: hold=%b done=%b err=%b required 1/0/0", cpu_hold, done, error); end
    checks++; if (rom_ce !== 4'b1111 || rom_a !== 13'd0) begin failures++;
      $display("[TB] FAIL reset_rom: ce=%b a=%h required 1111/0000", rom_ce, rom_a); end
    reset = 0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0 || cpu_hold !== 1'b1 || rom_ce !== 4'b1111) begin failures++;
      $display("[TB] FAIL idle_hold: ready=%b hold=%b ce=%b required 0/1/1111", in_ready, cpu_hold, rom_ce); end
  endtask

  task automatic test_full_load_with_start();
    int bad;
    bit to;
    logic [3:0] we;
    logic [12:0] a;
    logic [7:0] d;
    exp_sum = 16'hC000;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    checks++; if (in_ready !== 1'b1) begin failures++;
      $display("[TB] FAIL load_entry: ready=%b required 1", in_ready); end
    run_stream(32768, 0, 100, 8192, bad, to, we, a, d);
    checks++; if (to !== 1'b0 || bad !== 0) begin failures++;
      $display("[TB] FAIL full_stream: timeout=%0d bad_cycles=%0d required 0/0", to, bad); end
    checks++; if (we !== 4'b0010 || a !== 13'd0 || d !== 8'h01) begin failures++;
      $display("[TB] FAIL byte8192: we=%b a=%h d=%h required 0010/0000/01", we, a, d); end
    checks++; if (checksum !== 16'hC000 || in_ready !== 1'b0 || done !== 1'b0) begin failures++;
      $display("[TB] FAIL last_accept: sum=%h ready=%b done=%b required c000/0/0", checksum, in_ready, done); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0) begin failures++;
      $display("[TB] FAIL run_status: done=%b hold=%b err=%b required 1/0/0", done, cpu_hold, error); end
    cpu_a = 13'h1ABC; cpu_ce = 4'b1011;
    #1;
    checks++; if (rom_a !== 13'h1ABC || rom_ce !== 4'b1011) begin failures++;
      $display("[TB] FAIL run_passthru: a=%h ce=%b required 1abc/1011", rom_a, rom_ce); end
  endtask

  task automatic test_reload_run_gaps_mismatch();
    int bad;
    bit to;
    logic [3:0] we;
    logic [12:0] a;
    logic [7:0] d;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    checks++; if (in_ready !== 1'b1 || checksum !== 16'd0) begin failures++;
      $display("[TB] FAIL reload_run: ready=%b sum=%h required 1/0000", in_ready, checksum); end
    @(posedge clk); #1;
    checks++; if (cpu_hold !== 1'b1 || done !== 1'b0 || rom_ce !== 4'b1111) begin failures++;
      $display("[TB] FAIL reload_hold: hold=%b done=%b ce=%b required 1/0/1111", cpu_hold, done, rom_ce); end
    exp_sum = 16'hC001;
    run_stream(32768, 1, -1, 0, bad, to, we, a, d);
    checks++; if (to !== 1'b0 || bad !== 0) begin failures++;
      $display("[TB] FAIL gap_stream: timeout=%0d bad_cycles=%0d required 0/0", to, bad); end
    checks++; if (we !== 4'b0001 || a !== 13'd0 || d !== 8'h00) begin failures++;
      $display("[TB] FAIL reload_first_write: we=%b a=%h d=%h required 0001/0000/00", we, a, d); end
    checks++; if (checksum !== 16'hC000) begin failures++;
      $display("[TB] FAIL gap_sum: sum=%h required c000", checksum); end
    repeat (2) @(posedge clk);
    #1;
    cpu_ce = 4'b1110;
    #1;
    checks++; if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin failures++;
      $display("[TB] FAIL fail_status: err=%b hold=%b done=%b required 1/1/0", error, cpu_hold, done); end
    checks++; if (rom_ce !== 4'b1111 || rom_a !== 13'h1FFF) begin failures++;
      $display("[TB] FAIL fail_rom: ce=%b a=%h required 1111/1fff", rom_ce, rom_a); end
    start = 1;
    @(posedge clk); #1;
    start = 0;
    checks++; if (in_ready !== 1'b1 || checksum !== 16'd0) begin failures++;
      $display("[TB] FAIL fail_restart: ready=%b sum=%h required 1/0000", in_ready, checksum); end
    @(posedge clk); #1;
    checks++; if (error !== 1'b0) begin failures++;
      $display("[TB] FAIL error_clear: err=%b required 0", error); end
  endtask

  task automatic test_reset_mid_load();
    int bad;
    bit to;
    logic [3:0] we;
    logic [12:0] a;
    logic [7:0] d;
    run_stream(5000, 0, -1, 0, bad, to, we, a, d);
    checks++; if (to !== 1'b0 || bad !== 0 || wr_we !== 4'b0001 || wr_a !== 13'd4999) begin failures++;
      $display("[TB] FAIL partial_stream: timeout=%0d bad=%0d we=%b a=%h required 0/0/0001/1387", to, bad, wr_we, wr_a); end
    reset = 1;
    #1;
    checks++; if (wr_we !== 4'b0000 || wr_a !== 13'd0 || in_ready !== 1'b0 || checksum !== 16'd0) begin failures++;
      $display("[TB] FAIL async_reset: we=%b a=%h ready=%b sum=%h required 0000/0000/0/0000", wr_we, wr_a, in_ready, checksum); end
    checks++; if (cpu_hold !== 1'b1 || done !== 1'b0 || rom_ce !== 4'b1111 || rom_a !== 13'd0) begin failures++;
      $display("[TB] FAIL async_reset_rom: hold=%b done=%b ce=%b a=%h required 1/0/1111/0000", cpu_hold, done, rom_ce, rom_a); end
    @(posedge clk); #1;
    reset = 0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    run_stream(4, 0, -1, 0, bad, to, we, a, d);
    checks++; if (to !== 1'b0 || bad !== 0 || we !== 4'b0001 || a !== 13'd0 || d !== 8'h00) begin failures++;
      $display("[TB] FAIL restart_first_write: bad=%0d we=%b a=%h d=%h required 0/0001/0000/00", bad, we, a, d); end
    checks++; if (checksum !== 16'd6) begin failures++;
      $display("[TB] FAIL restart_sum: sum=%h required 0006", checksum); end
  endtask

  initial begin
    test_reset();
    test_full_load_with_start();
    test_reload_run_gaps_mismatch();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
